// File: rtl/serial_cmp_pkg.sv
// Shared types and reset constants for the framed serial magnitude comparator.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    CMP_LT = 2'd0,
    CMP_EQ = 2'd1,
    CMP_GT = 2'd2
  } cmp_res_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } frame_st_t;

  // Running-compare state at the start of every frame: "equal so far".
  localparam logic PREV_EQ_RST = 1'b1;
  localparam logic PREV_LT_RST = 1'b0;

endpackage

// File: rtl/serial_comparator_framed_if.sv
// Digit-stream and result bus of the framed serial comparator.
// master drives digits and consumes results; slave is the comparator.
interface serial_comparator_framed_if
  import serial_cmp_pkg::*;
#(
  parameter int DIGIT_W    = 1,
  parameter int MAX_DIGITS = 16
);
  localparam int CW = $clog2(MAX_DIGITS + 1);

  logic               msb_first;
  logic               valid;
  logic               last;
  logic [DIGIT_W-1:0] a;
  logic [DIGIT_W-1:0] b;
  logic               a_less_b;
  logic               a_eq_b;
  logic               a_greater_b;
  logic               res_valid;
  cmp_res_t           res;
  logic [CW-1:0]      res_digits;
  logic               res_overflow;

  modport master (
    output msb_first, valid, last, a, b,
    input  a_less_b, a_eq_b, a_greater_b, res_valid, res, res_digits, res_overflow
  );

  modport slave (
    input  msb_first, valid, last, a, b,
    output a_less_b, a_eq_b, a_greater_b, res_valid, res, res_digits, res_overflow
  );

endinterface

// File: rtl/serial_cmp_digit.sv
// Single-digit unsigned compare. With SERIAL_CMP_SIGNED_EN defined, the sign
// digit has its top bit flipped in both operands, which turns the unsigned
// compare into a two's-complement compare for that digit.
module serial_cmp_digit #(
  parameter int DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] a_i,
  input  logic [DIGIT_W-1:0] b_i,
  input  logic               sign_digit_i,
  output logic               dlt_o,
  output logic               deq_o
);

  logic [DIGIT_W-1:0] a_adj;
  logic [DIGIT_W-1:0] b_adj;

`ifdef SERIAL_CMP_SIGNED_EN
  // Bias the sign digit so the plain magnitude compare orders negatives first.
  always_comb begin
    a_adj = a_i;
    b_adj = b_i;
    if (sign_digit_i) begin
      a_adj[DIGIT_W-1] = ~a_i[DIGIT_W-1];
      b_adj[DIGIT_W-1] = ~b_i[DIGIT_W-1];
    end
  end
`else
  logic sign_unused;
  assign sign_unused = sign_digit_i;
  assign a_adj = a_i;
  assign b_adj = b_i;
`endif

  assign dlt_o = (a_adj < b_adj);
  assign deq_o = (a_adj == b_adj);

endmodule

// File: rtl/serial_comparator_framed.sv
// Framed serial magnitude comparator: DIGIT_W bits per cycle, MSB- or
// LSB-first per frame, registered LT/EQ/GT pulse at frame end.
// Optional: SERIAL_CMP_SIGNED_EN selects two's-complement operands.
module serial_comparator_framed
  import serial_cmp_pkg::*;
#(
  parameter int DIGIT_W    = 1,
  parameter int MAX_DIGITS = 16
) (
  input logic                        clk,
  input logic                        rst,
  serial_comparator_framed_if.slave  bus
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  frame_st_t     state_q, state_d;
  logic          mode_q, mode_d;
  logic          prev_eq_q, prev_eq_d;
  logic          prev_lt_q, prev_lt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          res_valid_q, res_valid_d;
  cmp_res_t      res_q, res_d;
  logic [CW-1:0] res_digits_q, res_digits_d;
  logic          res_ovf_q, res_ovf_d;

  logic mode, close, sign_digit, dlt, deq, eq_new, lt_new;

  // Order is taken live on the first digit, then frozen for the frame.
  assign mode  = (state_q == ST_IDLE) ? bus.msb_first : mode_q;
  assign close = bus.valid & (bus.last | (cnt_q == CW'(MAX_DIGITS - 1)));
  // Sign lives in the first digit MSB-first, in the closing digit LSB-first.
  assign sign_digit = mode ? (state_q == ST_IDLE) : close;

  serial_cmp_digit #(.DIGIT_W(DIGIT_W)) u_digit (
    .a_i          (bus.a),
    .b_i          (bus.b),
    .sign_digit_i (sign_digit),
    .dlt_o        (dlt),
    .deq_o        (deq)
  );

  // MSB-first: earlier digits dominate. LSB-first: the newest digit dominates.
  assign eq_new = prev_eq_q & deq;
  assign lt_new = mode ? (prev_lt_q | (prev_eq_q & dlt)) : (dlt | (deq & prev_lt_q));

  assign bus.a_less_b     = bus.valid ? lt_new : prev_lt_q;
  assign bus.a_eq_b       = bus.valid ? eq_new : prev_eq_q;
  assign bus.a_greater_b  = ~bus.a_less_b & ~bus.a_eq_b;
  assign bus.res_valid    = res_valid_q;
  assign bus.res          = res_q;
  assign bus.res_digits   = res_digits_q;
  assign bus.res_overflow = res_ovf_q;

  // Frame sequencing, running compare state and result capture.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    prev_eq_d    = prev_eq_q;
    prev_lt_d    = prev_lt_q;
    cnt_d        = cnt_q;
    res_valid_d  = 1'b0;
    res_d        = res_q;
    res_digits_d = res_digits_q;
    res_ovf_d    = res_ovf_q;
    if (bus.valid) begin
      if (close) begin
        state_d      = ST_IDLE;
        prev_eq_d    = PREV_EQ_RST;
        prev_lt_d    = PREV_LT_RST;
        cnt_d        = '0;
        res_valid_d  = 1'b1;
        res_d        = lt_new ? CMP_LT : (eq_new ? CMP_EQ : CMP_GT);
        res_digits_d = cnt_q + CW'(1);
        res_ovf_d    = ~bus.last;
      end else begin
        state_d   = ST_FRAME;
        mode_d    = mode;
        prev_eq_d = eq_new;
        prev_lt_d = lt_new;
        cnt_d     = cnt_q + CW'(1);
      end
    end
  end

  // State register; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= 1'b1;
      prev_eq_q    <= PREV_EQ_RST;
      prev_lt_q    <= PREV_LT_RST;
      cnt_q        <= '0;
      res_valid_q  <= 1'b0;
      res_q        <= CMP_EQ;
      res_digits_q <= '0;
      res_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      prev_eq_q    <= prev_eq_d;
      prev_lt_q    <= prev_lt_d;
      cnt_q        <= cnt_d;
      res_valid_q  <= res_valid_d;
      res_q        <= res_d;
      res_digits_q <= res_digits_d;
      res_ovf_q    <= res_ovf_d;
    end
  end

endmodule

// File: tb/tb_serial_comparator_framed.sv
// Bench for serial_comparator_framed: two instances (1-bit/16-digit and
// 4-bit/8-digit) checked against an operand-value reference model.
module tb_serial_comparator_framed;
  import serial_cmp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_comparator_framed_if #(.DIGIT_W(1), .MAX_DIGITS(16)) b1 ();
  serial_comparator_framed_if #(.DIGIT_W(4), .MAX_DIGITS(8))  b4 ();

  serial_comparator_framed #(.DIGIT_W(1), .MAX_DIGITS(16)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  serial_comparator_framed #(.DIGIT_W(4), .MAX_DIGITS(8))  dut4 (.clk(clk), .rst(rst), .bus(b4));

  int checks = 0;
  int errors = 0;

  // Reference model state per unit: collected digits of the open frame.
  bit       inf   [2];
  bit       mode_m[2];
  int       n     [2];
  longint   da    [2][16];
  longint   db    [2][16];
  bit       plt   [2];
  bit       peq   [2];
  cmp_res_t lres  [2];
  int       ldig  [2];
  bit       lovf  [2];

  function automatic int wid(int u);  return (u == 0) ? 1 : 4;  endfunction
  function automatic int maxd(int u); return (u == 0) ? 16 : 8; endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Rebuild both operands as integers from the digits seen so far and compare.
  function automatic void model(int u, bit closing, output bit lt, output bit eq);
    longint va = 0, vb = 0;
    int w = wid(u);
    int k = n[u];
    for (int i = 0; i < k; i++) begin
      if (mode_m[u]) begin
        va = (va << w) | da[u][i];
        vb = (vb << w) | db[u][i];
      end else begin
        va = va | (da[u][i] << (i * w));
        vb = vb | (db[u][i] << (i * w));
      end
    end
`ifdef SERIAL_CMP_SIGNED_EN
    if (mode_m[u] || closing) begin
      if (va[k*w-1]) va = va - (64'sd1 <<< (k * w));
      if (vb[k*w-1]) vb = vb - (64'sd1 <<< (k * w));
    end
`else
    if (closing) begin end
`endif
    lt = (va < vb);
    eq = (va == vb);
  endfunction

  task automatic drive(int u, bit v, bit l, logic [3:0] xa, logic [3:0] xb, bit m);
    b1.valid = (u == 0) && v; b1.last = l; b1.a = xa[0:0]; b1.b = xb[0:0]; b1.msb_first = m;
    b4.valid = (u == 1) && v; b4.last = l; b4.a = xa;      b4.b = xb;      b4.msb_first = m;
  endtask

  task automatic get_run(int u, output logic lt, output logic eq, output logic gt);
    if (u == 0) begin lt = b1.a_less_b; eq = b1.a_eq_b; gt = b1.a_greater_b; end
    else        begin lt = b4.a_less_b; eq = b4.a_eq_b; gt = b4.a_greater_b; end
  endtask

  task automatic get_res(int u, output logic rv, output logic [1:0] rs,
                         output logic [4:0] dg, output logic ov);
    if (u == 0) begin rv = b1.res_valid; rs = b1.res; dg = 5'(b1.res_digits); ov = b1.res_overflow; end
    else        begin rv = b4.res_valid; rs = b4.res; dg = 5'(b4.res_digits); ov = b4.res_overflow; end
  endtask

  function automatic void model_reset(int u);
    inf[u] = 0; n[u] = 0; plt[u] = 0; peq[u] = 1;
  endfunction

  // One cycle on unit u: check running flags mid-cycle, result after the edge.
  task automatic step(int u, bit v, bit l, logic [3:0] xa, logic [3:0] xb, bit m);
    bit lt, eq, closing;
    logic olt, oeq, ogt, rv, ov;
    logic [1:0] rs;
    logic [4:0] dg;
    logic [3:0] mask;
    mask = (u == 0) ? 4'h1 : 4'hF;
    @(negedge clk);
    drive(u, v, l, xa, xb, m);
    closing = 0;
    if (v) begin
      if (!inf[u]) begin inf[u] = 1; mode_m[u] = m; n[u] = 0; end
      da[u][n[u]] = longint'(xa & mask);
      db[u][n[u]] = longint'(xb & mask);
      n[u]++;
      closing = l || (n[u] == maxd(u));
      model(u, closing, lt, eq);
    end else begin
      lt = plt[u]; eq = peq[u];
    end
    #1;
    get_run(u, olt, oeq, ogt);
    chk("a_less_b", 64'(olt), 64'(lt));
    chk("a_eq_b", 64'(oeq), 64'(eq));
    chk("a_greater_b", 64'(ogt), 64'(!lt && !eq));
    @(posedge clk);
    #1;
    if (closing) begin
      lres[u] = lt ? CMP_LT : (eq ? CMP_EQ : CMP_GT);
      ldig[u] = n[u];
      lovf[u] = !l;
      model_reset(u);
    end else if (v) begin
      plt[u] = lt; peq[u] = eq;
    end
    get_res(u, rv, rs, dg, ov);
    chk("res_valid", 64'(rv), 64'(closing));
    chk("res", 64'(rs), 64'(lres[u]));
    chk("res_digits", 64'(dg), 64'(ldig[u]));
    chk("res_overflow", 64'(ov), 64'(lovf[u]));
  endtask

  task automatic do_reset();
    logic olt, oeq, ogt, rv, ov;
    logic [1:0] rs;
    logic [4:0] dg;
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 4'h0, 4'h0, 1);
    @(posedge clk); @(posedge clk); #1;
    for (int u = 0; u < 2; u++) begin
      get_run(u, olt, oeq, ogt);
      get_res(u, rv, rs, dg, ov);
      chk("rst_a_less_b", 64'(olt), 64'd0);
      chk("rst_a_eq_b", 64'(oeq), 64'd1);
      chk("rst_a_greater_b", 64'(ogt), 64'd0);
      chk("rst_res_valid", 64'(rv), 64'd0);
      chk("rst_res", 64'(rs), 64'(CMP_EQ));
      chk("rst_res_digits", 64'(dg), 64'd0);
      chk("rst_res_overflow", 64'(ov), 64'd0);
      model_reset(u);
      lres[u] = CMP_EQ; ldig[u] = 0; lovf[u] = 0;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] opa, opb;
    opa = 16'b0110_0100_1000_0010;
    opb = 16'b0110_0010_0110_0010;
    rst = 1'b1;
    drive(0, 0, 0, 4'h0, 4'h0, 1);
    do_reset();

    // MSB-first 16-bit frame: equal for 5 digits, then A ahead.
    for (int i = 0; i < 16; i++) step(0, 1, i == 15, {3'b0, opa[15-i]}, {3'b0, opb[15-i]}, 1);
    // Same operands LSB-first.
    for (int i = 0; i < 16; i++) step(0, 1, i == 15, {3'b0, opa[i]}, {3'b0, opb[i]}, 0);

    // 4-bit digits, equal operands with gaps that must hold the flags.
    step(1, 1, 0, 4'h3, 4'h3, 1);
    step(1, 0, 0, 4'($urandom), 4'($urandom), 0);
    step(1, 0, 1, 4'($urandom), 4'($urandom), 0);
    step(1, 1, 1, 4'hA, 4'hA, 0);

    // Back-to-back single-digit frames.
    step(1, 1, 1, 4'h5, 4'h3, 1);
    step(1, 1, 1, 4'h1, 4'h2, 1);

    // 17 digits without last: overflow close, digit 17 opens a new frame.
    for (int i = 0; i < 17; i++) step(0, 1, 0, 4'($urandom), 4'($urandom), 1'($urandom));
    step(0, 1, 1, 4'($urandom), 4'($urandom), 1);

    // 0xF0 vs 0x10: LT when signed, GT when unsigned.
    step(1, 1, 0, 4'hF, 4'h1, 1);
    step(1, 1, 1, 4'h0, 4'h0, 1);

    // Reset in the middle of a frame produces no result.
    step(1, 1, 0, 4'h2, 4'h7, 1);
    step(1, 1, 0, 4'h4, 4'h4, 0);
    do_reset();
    step(1, 0, 0, 4'h0, 4'h0, 1);

    // Random traffic on both units: gaps, stray last, mid-frame order changes.
    for (int i = 0; i < 600; i++)
      step(int'($urandom_range(0, 1)), ($urandom % 4) != 0, ($urandom % 5) == 0,
           4'($urandom), 4'($urandom), 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
